// File: rtl/mem_pkg.sv
// Shared constants for the memory-access stage: funct3 codes, write-back source
// selects, FSM state encoding and access-size decode.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] SRC_ALU = 2'b00;
  localparam logic [1:0] SRC_MEM = 2'b01;
  localparam logic [1:0] SRC_PC4 = 2'b10;

  typedef logic [1:0] state_t;
  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_BUSY = 2'd1;
  localparam state_t S_DONE = 2'd2;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  // Unsigned variants only exist for loads; anything undefined is a word access.
  function automatic logic [1:0] access_size(input logic [2:0] f3, input logic is_load);
    logic [1:0] sz;
    sz = SZ_W;
    case (f3)
      F3_B:    sz = SZ_B;
      F3_H:    sz = SZ_H;
      F3_W:    sz = SZ_W;
      F3_BU:   sz = is_load ? SZ_B : SZ_W;
      F3_HU:   sz = is_load ? SZ_H : SZ_W;
      default: sz = SZ_W;
    endcase
    return sz;
  endfunction

endpackage

// File: rtl/load_align.sv
// Selects the addressed byte/halfword of a load word and sign- or zero-extends it.
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = addr[1] ? rdata[31:16] : rdata[15:0];

    case (funct3)
      F3_B:    result = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    result = {{16{half_sel[15]}}, half_sel};
      F3_BU:   result = {24'd0, byte_sel};
      F3_HU:   result = {16'd0, half_sel};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// Memory-access stage with MEM/WB register; optional misalignment trap when
// MEM_ALIGN_CHECK_EN is defined (adds the MEM_MisalignErr port).
module mem_access
  import mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
`ifdef MEM_ALIGN_CHECK_EN
  output logic        MEM_MisalignErr,
`endif
  input  logic        MEM_Valid,
  input  logic        MEM_RegWrite,
  input  logic [4:0]  MEM_RD,
  input  logic [1:0]  MEM_RegWriteSrc,
  input  logic        MEM_MemRead,
  input  logic        MEM_MemWrite,
  input  logic [2:0]  MEM_Funct3,
  input  logic [31:0] MEM_AluResult,
  input  logic [31:0] MEM_WriteData,
  input  logic [31:0] MEM_PCPlus4,
  output logic        MEM_Stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        WB_RegWrite,
  output logic [4:0]  WB_RD,
  output logic [1:0]  WB_RegWriteSrc,
  output logic [31:0] WB_AluResult,
  output logic [31:0] WB_ReadData,
  output logic [31:0] WB_PCPlus4
);

  state_t      state_q, state_d;
  logic [31:0] rdata_q, rdata_d;
  logic        wb_regwrite_q, wb_regwrite_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic [1:0]  wb_src_q, wb_src_d;
  logic [31:0] wb_alu_q, wb_alu_d;
  logic [31:0] wb_rdata_q, wb_rdata_d;
  logic [31:0] wb_pc4_q, wb_pc4_d;
  logic        err_q, err_d;

  logic        is_mem, is_load, misalign, busy;
  logic [1:0]  size;
  logic [31:0] load_val;
  logic [3:0]  be;
  logic [31:0] wdata;

  assign is_load = MEM_Valid & MEM_MemRead;
  assign is_mem  = MEM_Valid & (MEM_MemRead | MEM_MemWrite);
  assign size    = access_size(MEM_Funct3, MEM_MemRead);
  assign busy    = (state_q == S_BUSY);

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = is_mem & (((size == SZ_H) & MEM_AluResult[0]) |
                              ((size == SZ_W) & (MEM_AluResult[1:0] != 2'b00)));
  assign MEM_MisalignErr = err_q;
`else
  assign misalign = 1'b0;
`endif

  load_align u_load_align (
    .rdata  (rdata_q),
    .addr   (MEM_AluResult[1:0]),
    .funct3 (MEM_Funct3),
    .result (load_val)
  );

  always_comb begin
    case (size)
      SZ_B: begin
        be    = 4'b0001 << MEM_AluResult[1:0];
        wdata = {4{MEM_WriteData[7:0]}};
      end
      SZ_H: begin
        be    = MEM_AluResult[1] ? 4'b1100 : 4'b0011;
        wdata = {2{MEM_WriteData[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = MEM_WriteData;
      end
    endcase
  end

  assign dmem_req   = busy;
  assign dmem_we    = busy & MEM_MemWrite;
  assign dmem_addr  = busy ? {MEM_AluResult[31:2], 2'b00} : 32'd0;
  assign dmem_be    = busy ? be : 4'd0;
  assign dmem_wdata = busy ? wdata : 32'd0;
  // Gated by rst_n so the stall drops the moment reset is asserted.
  assign MEM_Stall  = rst_n & (((state_q == S_IDLE) & is_mem) | busy);

  always_comb begin
    state_d       = state_q;
    rdata_d       = rdata_q;
    wb_regwrite_d = 1'b0;
    wb_rd_d       = 5'd0;
    wb_src_d      = 2'b00;
    wb_alu_d      = 32'd0;
    wb_rdata_d    = 32'd0;
    wb_pc4_d      = 32'd0;
    err_d         = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (is_mem) begin
          state_d = misalign ? S_DONE : S_BUSY;
        end else if (MEM_Valid) begin
          wb_regwrite_d = MEM_RegWrite;
          wb_rd_d       = MEM_RD;
          wb_src_d      = MEM_RegWriteSrc;
          wb_alu_d      = MEM_AluResult;
          wb_pc4_d      = MEM_PCPlus4;
        end
      end
      S_BUSY: begin
        if (dmem_ready) begin
          rdata_d = dmem_rdata;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        wb_regwrite_d = MEM_RegWrite & ~misalign;
        wb_rd_d       = MEM_RD;
        wb_src_d      = MEM_RegWriteSrc;
        wb_alu_d      = MEM_AluResult;
        wb_rdata_d    = (is_load & ~misalign) ? load_val : 32'd0;
        wb_pc4_d      = MEM_PCPlus4;
        err_d         = misalign;
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      rdata_q       <= 32'd0;
      wb_regwrite_q <= 1'b0;
      wb_rd_q       <= 5'd0;
      wb_src_q      <= 2'b00;
      wb_alu_q      <= 32'd0;
      wb_rdata_q    <= 32'd0;
      wb_pc4_q      <= 32'd0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      rdata_q       <= rdata_d;
      wb_regwrite_q <= wb_regwrite_d;
      wb_rd_q       <= wb_rd_d;
      wb_src_q      <= wb_src_d;
      wb_alu_q      <= wb_alu_d;
      wb_rdata_q    <= wb_rdata_d;
      wb_pc4_q      <= wb_pc4_d;
      err_q         <= err_d;
    end
  end

`ifndef MEM_ALIGN_CHECK_EN
  logic unused_err;
  assign unused_err = err_q;
`endif

  assign WB_RegWrite    = wb_regwrite_q;
  assign WB_RD          = wb_rd_q;
  assign WB_RegWriteSrc = wb_src_q;
  assign WB_AluResult   = wb_alu_q;
  assign WB_ReadData    = wb_rdata_q;
  assign WB_PCPlus4     = wb_pc4_q;

endmodule

// File: doc/mem_access.md
# mem_access

Memory-access stage plus MEM/WB pipeline register: it takes the EX/MEM bundle, performs loads and stores on a ready-handshaked data-memory port, and registers the result bundle that the write-back stage consumes. It aligns loads and sign/zero-extends them. It generates byte enables for stores. It stalls the upstream pipeline while a memory transaction is outstanding.

## Interface
- No parameters; data/address width fixed at 32.
- clk  in  1  pipeline clock
- rst_n  in  1  reset, asynchronous, active-low
- MEM_Valid  in  1  stage holds a real instruction
- MEM_RegWrite  in  1  instruction writes rd
- MEM_RD  in  5  destination register
- MEM_RegWriteSrc  in  2  00 ALU, 01 memory, 10 PC+4
- MEM_MemRead / MEM_MemWrite  in  1 each  load / store (never both)
- MEM_Funct3  in  3  access size/sign (RV32I encoding)
- MEM_AluResult  in  32  effective address or ALU result
- MEM_WriteData  in  32  store data (rs2)
- MEM_PCPlus4  in  32  link value
- MEM_Stall  out  1  hold EX/MEM and earlier stages
- dmem_req  out  1  transaction request
- dmem_we  out  1  1 = store
- dmem_addr  out  32  word address, bits [1:0] = 0
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-shifted store data
- dmem_ready  in  1  transaction complete this cycle
- dmem_rdata  in  32  load word, valid when dmem_ready
- WB_RegWrite, WB_RD, WB_RegWriteSrc, WB_AluResult, WB_ReadData, WB_PCPlus4  out  1/5/2/32/32/32  registered bundle to write-back
- MEM_MisalignErr  out  1  registered, present only with MEM_ALIGN_CHECK_EN

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - Non-memory valid instruction: bundle registered into WB next edge, no stall.
  - Load or store: MEM_Stall=1, go to BUSY, and a bubble is loaded into WB (WB_RegWrite=0).
- BUSY:
  - dmem_req=1, with addr, we, be and wdata held stable; MEM_Stall=1; WB holds a bubble.
  - On dmem_ready=1, dmem_rdata is captured and the FSM goes to DONE.
- DONE:
  - MEM_Stall=0; the WB register loads the bundle with the extended ReadData; go to IDLE.
- Upstream keeps MEM_* stable while MEM_Stall=1.
- Store byte enables:
  - SB (000): be = 1<<addr[1:0], byte replicated to all lanes.
  - SH (001): be = 0011 or 1100 by addr[1], half replicated.
  - SW (010): be = 1111.
- Loads:
  - Byte/half selected by addr[1:0]/addr[1].
  - LB/LH sign-extend; LBU (100)/LHU (101) zero-extend; LW (010) passes through.
- Undefined funct3 values are treated as word access.
- MEM_Valid=0 loads a bubble and keeps the FSM in IDLE.
- WB_ReadData is 0 for non-load instructions.

## Timing
- Reset: all outputs 0, FSM to IDLE; asynchronous, takes effect mid-transaction (dmem_req drops immediately).
- Non-memory latency: 1 cycle to WB.
- Memory latency: 2 + N cycles, where N = cycles BUSY waits for dmem_ready.
  - dmem_ready in the first BUSY cycle gives a 3-cycle total.
- dmem_ready is ignored outside BUSY.
- dmem_req is never asserted for two transactions back to back without passing through DONE.
- Load followed immediately by a load: second transaction enters BUSY one cycle after DONE.

## Configuration
- MEM_ALIGN_CHECK_EN defined:
  - Misaligned access is detected: halfword with addr[0]=1, or word with addr[1:0]≠0.
  - Detection goes straight to DONE with no dmem_req.
  - WB_RegWrite=0 and MEM_MisalignErr=1 for that one WB cycle.
- MEM_ALIGN_CHECK_EN undefined:
  - No check; low address bits are truncated (half uses addr[1] only, word ignores [1:0]).
  - MEM_MisalignErr port absent.

## Structure
- Package mem_pkg: funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU), RegWriteSrc constants, FSM state enum.
- Sub-module load_align (combinational): rdata, addr[1:0], funct3 → extended 32-bit value; reused by the store-lane logic inverse only in this block.

## Test plan
- ADD result 0x0000_0042, rd=5, src=00 → WB_AluResult=0x42, WB_RegWrite=1 one cycle later, MEM_Stall never high.
- LB at 0x103, dmem_rdata=0x80FF_0000, ready in first BUSY cycle → dmem_addr=0x100, WB_ReadData=0xFFFF_FF80, MEM_Stall high exactly 2 cycles.
- SH data 0x1234 at 0x202, ready after 3 wait cycles → dmem_be=1100, dmem_wdata=0x1234_1234, request stable 4 cycles, WB_RegWrite=0.
- LHU at 0x2 with rdata 0xBEEF_0000 → 0x0000_BEEF; LH same → 0xFFFF_BEEF.
- LW at 0x101: with macro → no dmem_req, MEM_MisalignErr=1, WB_RegWrite=0; without → dmem_addr=0x100.
- rst_n low during BUSY → dmem_req and MEM_Stall drop immediately, WB outputs 0, FSM IDLE after release.
